// File: rtl/sprite_pkg.sv
// sprite_pkg: geometry, pixel width and writer state encoding shared by the sprite image writer and renderer.
package sprite_pkg;
  localparam int IMG_WIDTH  = 256;
  localparam int IMG_HEIGHT = 256;
  localparam int PIX_W      = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t WAIT_SOF = 2'd1;
  localparam state_t WRITE    = 2'd2;
  localparam state_t DONE     = 2'd3;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/raster_addr_counter.sv
// raster_addr_counter: x/y/linear-address raster counter without a multiplier.
// clr and en together restart the raster and advance it past pixel 0 in the same cycle.
module raster_addr_counter
  import sprite_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT),
  parameter int XW     = cnt_w(WIDTH),
  parameter int YW     = cnt_w(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [XW-1:0]     x_out,
  output logic [YW-1:0]     y_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_out
);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT-1);
  logic [XW-1:0] x_q, x_d, x_base;
  logic [YW-1:0] y_q, y_d, y_base;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_base;
  always_comb begin
    x_base    = clr ? '0 : x_q;
    y_base    = clr ? '0 : y_q;
    addr_base = clr ? '0 : addr_q;
    x_d       = !en ? x_base : (x_base == X_MAX) ? '0 : x_base + XW'(1);
    y_d       = (!en || x_base != X_MAX) ? y_base : (y_base == Y_MAX) ? '0 : y_base + YW'(1);
    addr_d    = !en ? addr_base : (x_base == X_MAX && y_base == Y_MAX) ? '0 : addr_base + ADDR_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end
  assign x_out    = x_q;
  assign y_out    = y_q;
  assign addr_out = addr_q;
  assign last_out = x_q == X_MAX && y_q == Y_MAX;
endmodule

// File: rtl/sprite_image_writer.sv
// sprite_image_writer: captures one raster frame of palette indices per start command
// into the image RAM write port, with one cycle of registered write latency.
module sprite_image_writer
  import sprite_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              sof_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [PIX_W-1:0]  bram_data_out,
  output logic              bram_we_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              sync_err_out
);
  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, addr;
  logic [PIX_W-1:0] data_q, data_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d;
  logic accept, sof_beat, wr, last;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  raster_addr_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .XW(XW), .YW(YW)) u_cnt (
    .clk(pixel_clk_in),
    .rst(rst_in),
    .clr(sof_beat),
    .en(wr),
    .x_out(x),
    .y_out(y),
    .addr_out(addr),
    .last_out(last)
  );
  assign ready_out = state_q == WAIT_SOF || state_q == WRITE;
  assign busy_out  = state_q != IDLE;
  always_comb begin
    accept   = valid_in && ready_out;
    sof_beat = accept && sof_in;
    wr       = sof_beat || (accept && state_q == WRITE);
    state_d  = (state_q == IDLE)     ? (start_in ? WAIT_SOF : IDLE) :
               (state_q == WAIT_SOF) ? (sof_beat ? WRITE : WAIT_SOF) :
               (state_q == WRITE)    ? ((wr && !sof_in && last) ? DONE : WRITE) :
                                       IDLE;
    waddr_d  = !wr ? waddr_q : sof_in ? '0 : addr;
    data_d   = wr ? pixel_in : data_q;
    we_d     = wr;
    done_d   = state_q == WRITE && state_d == DONE;
    // a restart sof only counts as an error when the raster had already moved off the origin
    err_d    = sof_beat && state_q == WRITE && !(x == '0 && y == '0);
  end
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      waddr_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bram_addr_out  = waddr_q;
  assign bram_data_out  = data_q;
  assign bram_we_out    = we_q;
  assign frame_done_out = done_q;
  assign sync_err_out   = err_q;
endmodule

// File: doc/sprite_image_writer.md
Name: sprite_image_writer

Overview:
- Write-side counterpart of the sprite image BROM path. Accepts a raster-ordered stream of 8-bit palette indices (valid/ready, start-of-frame flag) and writes them into the write port of the true-dual-port image RAM that the sprite renderer reads.
- Sits between the camera/capture front end and the image RAM. Produces one full WIDTH*HEIGHT image per start command, then signals completion.

Parameters:
- WIDTH, 256, image width in pixels
- HEIGHT, 256, image height in pixels
- ADDR_W, $clog2(WIDTH*HEIGHT), RAM address width (derived; do not override)

Ports:
- pixel_clk_in  input  1  sole clock, rising edge
- rst_in  input  1  asynchronous, active-high reset
- start_in  input  1  one-cycle request to capture the next frame
- pixel_in  input  8  palette index of the current beat
- sof_in  input  1  current beat is pixel (0,0) of a frame; qualified by valid_in
- valid_in  input  1  beat valid
- ready_out  output  1  writer accepts the beat this cycle
- bram_addr_out  output  ADDR_W  RAM write address
- bram_data_out  output  8  RAM write data
- bram_we_out  output  1  RAM write enable
- busy_out  output  1  high in every state except IDLE
- frame_done_out  output  1  one-cycle pulse after the last pixel is written
- sync_err_out  output  1  one-cycle pulse on an unexpected sof_in mid-frame

Behaviour:
- Clock and reset: single clock pixel_clk_in; rst_in is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, counters x=0, y=0, addr=0. Reset asserted mid-frame drops bram_we_out immediately. No partial write may be issued after reset releases.
- Accept condition: a beat is accepted when valid_in && ready_out.
- ready_out is combinational from state only: 1 in WAIT_SOF and WRITE, 0 in IDLE and DONE.
- Write latency: exactly 1 cycle. An accepted beat appears on bram_addr_out, bram_data_out and bram_we_out=1 on the next cycle. All three outputs are registered.
- bram_we_out=0 on any cycle that follows a non-accepted cycle.
- Addressing: no multiplier. addr increments by 1 per written pixel. x counts 0..WIDTH-1; on wrap x=0 and y increments. addr always equals y*WIDTH+x.
- IDLE:
  - start_in=1 -> WAIT_SOF.
  - Beats are not accepted.
- WAIT_SOF:
  - Accepted beats with sof_in=0 are discarded (no write).
  - An accepted beat with sof_in=1 writes addr 0, sets x=1, y=0, addr=1, and moves to WRITE.
- WRITE:
  - Each accepted beat writes at the current addr, then advances the counters.
  - The beat at x=WIDTH-1, y=HEIGHT-1 is written, then the state moves to DONE.
  - An accepted beat with sof_in=1 at any addr other than 0 pulses sync_err_out on the next cycle and writes that beat at addr 0. Counters restart at x=1, addr=1, and the state stays in WRITE.
- DONE: lasts one cycle. frame_done_out=1 coincides with the cycle in which the final write's bram_we_out is high. Then -> IDLE.
- start_in outside IDLE is ignored. start_in and an accepted beat cannot coincide, because ready_out=0 in IDLE.
- valid_in gaps in WAIT_SOF or WRITE hold all state; no timeout.
- Beats arriving after the final pixel (in DONE or IDLE) are back-pressured, never written.
- busy_out is high in WAIT_SOF, WRITE and DONE.

Decomposition:
- Shared package (sprite_pkg):
  - state enum: IDLE, WAIT_SOF, WRITE, DONE
  - IMG_WIDTH and IMG_HEIGHT default constants, shared with the sprite renderer so both agree on geometry
  - PIX_W=8 constant
- One natural sub-module: raster_addr_counter. It holds x/y/addr with clear, enable, wrap and a last flag, and is reusable by the renderer.

Test Plan:
- Full frame, WIDTH=4, HEIGHT=2, continuous valid with sof on beat 0, data 0x10..0x17 -> 8 writes at addr 0..7 with data 0x10..0x17; frame_done_out pulses with the addr-7 write; busy_out falls the next cycle.
- Pre-sof garbage: 3 beats with sof=0 (0xAA) then a sof frame -> no writes until the sof beat, which writes addr 0 with its data.
- Back-pressure and gaps: random valid_in deassertion mid-row -> writes only on accepted beats; addresses remain contiguous; row wrap at x=3 goes to addr 4.
- Mid-frame sof at addr 5 with data 0x77 -> sync_err_out pulses one cycle, addr 0 is written with 0x77, and the next beat writes addr 1.
- Extra beats after frame end and start_in asserted during WRITE -> ready_out=0 after the last pixel, no extra writes, start_in is ignored; a new start_in in IDLE re-arms WAIT_SOF.
- rst_in asserted asynchronously mid-row (between clock edges) -> bram_we_out and busy_out drop immediately; after release the block is in IDLE with addr=0 and no spurious write.
